tx_parity_stage: RTL

//  Parametrised parity stage for the UART TX path: takes a data word over valid/ready, computes parity over a

---
 rtl/tx_parity_pkg.sv | 35 +++
 rtl/tx_parity_skid.sv | 79 +++++++
 rtl/tx_parity_stage.sv | 75 +++++++
 3 files changed

// File: rtl/tx_parity_pkg.sv
// tx_parity_pkg: shared types and helpers for the UART TX/RX parity logic.
//   par_mode_t     : parity mode encoding (even/odd/mark/space)
//   DEF_DATA_WIDTH : default frame data width
//   PAR_MAX_W      : widest data word calc_parity accepts
//   calc_parity()  : parity over the low `len` bits of `data`; also used by the RX checker
package tx_parity_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned PAR_MAX_W      = 64;

  // Even parity bit makes the total ones count (data + parity) even.
  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data,
                                       input int unsigned           len,
                                       input par_mode_t             mode);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
      if (i < len) x = x ^ data[i];
    end
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tx_parity_skid.sv
// tx_parity_skid: generic 2-entry (output register + skid register) valid/ready buffer.
// Full throughput under backpressure; in_ready is a pure register output.
//   clk, rst           : clock, synchronous active-high reset
//   in_data/in_valid   : upstream payload and valid
//   in_ready           : buffer can accept (registered)
//   out_data/out_valid : downstream payload and valid (held while stalled)
//   out_ready          : downstream accepts
//   busy               : any entry occupied
module tx_parity_skid #(
  parameter int unsigned PAYLOAD_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  logic [PAYLOAD_W-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 accept, consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || consume) begin
      // Output slot frees this cycle. in_ready is low whenever the skid is
      // full, so a skid refill and a new accept can never coincide.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = out_valid_q | skid_valid_q;

endmodule

// File: rtl/tx_parity_stage.sv
// tx_parity_stage: UART TX parity stage. Masks the data word to the active
// length, computes the parity bit and buffers word + parity in a 2-entry skid.
// Optional macro TX_PARITY_ERR_INJ_EN adds input ERR_INJ, which inverts the
// parity bit of a word accepted with PAR_EN=1.
//   CLK, RST                 : clock, synchronous active-high reset
//   P_DATA, DATA_LEN         : data word, active bit count (0 or >DATA_WIDTH = full)
//   PAR_EN, PAR_MODE         : parity enable, mode (even/odd/mark/space)
//   DATA_VALID / DATA_READY  : input handshake (DATA_READY registered)
//   OUT_DATA, OUT_PAR_BIT, OUT_PAR_EN, OUT_VALID / OUT_READY : output word + handshake
//   BUSY                     : stage holds at least one word
module tx_parity_stage import tx_parity_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_PAR_BIT,
  output logic                  OUT_PAR_EN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
`ifdef TX_PARITY_ERR_INJ_EN
  input  logic                  ERR_INJ,
`endif
  output logic                  BUSY
);

  localparam int unsigned PAYLOAD_W = DATA_WIDTH + 2;

  int unsigned           len_eff;
  logic [DATA_WIDTH-1:0] masked;
  logic [PAR_MAX_W-1:0]  data_ext;
  logic                  par_bit;
  logic [PAYLOAD_W-1:0]  in_payload, out_payload;

  always_comb begin
    len_eff = DATA_WIDTH;
    if (DATA_LEN != '0 && 32'(DATA_LEN) <= DATA_WIDTH) len_eff = 32'(DATA_LEN);
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      masked[i] = (i < len_eff) ? P_DATA[i] : 1'b0;
    end
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = masked;
    par_bit                  = 1'b0;
    if (PAR_EN) begin
      par_bit = calc_parity(data_ext, len_eff, par_mode_t'(PAR_MODE));
`ifdef TX_PARITY_ERR_INJ_EN
      par_bit = par_bit ^ ERR_INJ;
`endif
    end
  end

  assign in_payload = {masked, par_bit, PAR_EN};

  tx_parity_skid #(.PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clk       (CLK),
    .rst       (RST),
    .in_data   (in_payload),
    .in_valid  (DATA_VALID),
    .in_ready  (DATA_READY),
    .out_data  (out_payload),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .busy      (BUSY)
  );

  assign {OUT_DATA, OUT_PAR_BIT, OUT_PAR_EN} = out_payload;

endmodule
